// File: rtl/uart_word_bridge_if.sv
// Handshake bundle between uart_word_bridge and its neighbours: UART RX bytes,
// assembled samples, result words, UART TX bytes and status.
interface uart_word_bridge_if #(
  parameter int BYTES_IN   = 4,
  parameter int BYTES_OUT  = 4,
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                         rx_data_i;
  logic                               rx_valid_i;
  logic [8*BYTES_IN-1:0]              sample_o;
  logic                               sample_valid_o;
  logic [8*BYTES_OUT-1:0]             result_i;
  logic                               result_valid_i;
  logic                               result_ready_o;
  logic [7:0]                         tx_data_o;
  logic                               tx_valid_o;
  logic                               tx_busy_i;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o;
  logic                               overflow_o;
  logic                               timeout_o;

  modport slave (
    input  rx_data_i, rx_valid_i, result_i, result_valid_i, tx_busy_i,
    output sample_o, sample_valid_o, result_ready_o, tx_data_o, tx_valid_o,
           fifo_level_o, overflow_o, timeout_o
  );

  modport master (
    output rx_data_i, rx_valid_i, result_i, result_valid_i, tx_busy_i,
    input  sample_o, sample_valid_o, result_ready_o, tx_data_o, tx_valid_o,
           fifo_level_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/uart_word_bridge.sv
// Byte/word bridge: packs UART RX bytes MSB-first into samples, and buffers
// result words in a FIFO that is serialised MSB-first to the UART TX.
module uart_word_bridge #(
  parameter int BYTES_IN       = 4,
  parameter int BYTES_OUT      = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  uart_word_bridge_if.slave  bus
);
  localparam int WI = 8 * BYTES_IN;
  localparam int WO = 8 * BYTES_OUT;
  localparam int CW = $clog2(BYTES_IN + 1);
  localparam int IW = (BYTES_OUT > 1) ? $clog2(BYTES_OUT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(BYTES_IN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BYTES_OUT - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  // ---------------- RX packing and partial-frame timeout ----------------
  logic [WI-1:0] shift_q, shift_d, sample_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] idle_q;
  logic          sample_valid_q, timeout_q;

  assign shift_d = (shift_q << 8) | WI'(bus.rx_data_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q        <= '0;
      sample_q       <= '0;
      cnt_q          <= '0;
      idle_q         <= '0;
      sample_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      if (bus.rx_valid_i) begin
        shift_q <= shift_d;
        idle_q  <= '0;
        if (cnt_q == CNT_LAST) begin
          cnt_q          <= '0;
          sample_q       <= shift_d;
          sample_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (TIMEOUT_CYCLES != 0 && cnt_q != '0) begin
        // a byte arriving on the expiry cycle wins, handled by the branch above
        if (idle_q == IDLE_LAST) begin
          cnt_q     <= '0;
          idle_q    <= '0;
          timeout_q <= 1'b1;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  // ---------------- result word FIFO ----------------
  logic [WO-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          overflow_q, full, push, pop;

  assign full = (level_q == LVL_FULL);
  assign push = bus.result_valid_i && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.result_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      if (bus.result_valid_i && full) overflow_q <= 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_DRAIN} state_t;

  state_t        state_q;
  logic [WO-1:0] word_q, word_d;
  logic [IW-1:0] idx_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;

  always_comb begin
    pop = 1'b0;
    if (level_q != '0 && !bus.tx_busy_i)
      pop = (state_q == S_IDLE) || (state_q == S_DRAIN && idx_q == IDX_LAST);
  end

  assign word_d = pop ? mem_q[rd_q] : (word_q << 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pop) begin
          word_q     <= word_d;
          tx_data_q  <= word_d[WO-1 -: 8];
          tx_valid_q <= 1'b1;
          idx_q      <= '0;
          state_q    <= S_SEND;
        end
        S_SEND:  state_q <= S_GUARD;
        // transmitter may not have raised busy yet, so GUARD never looks at it
        S_GUARD: state_q <= S_DRAIN;
        S_DRAIN: if (!bus.tx_busy_i) begin
          if (idx_q != IDX_LAST || pop) begin
            word_q     <= word_d;
            tx_data_q  <= word_d[WO-1 -: 8];
            tx_valid_q <= 1'b1;
            idx_q      <= pop ? '0 : idx_q + 1'b1;
            state_q    <= S_SEND;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = sample_valid_q;
  assign bus.result_ready_o = !full;
  assign bus.tx_data_o      = tx_data_q;
  assign bus.tx_valid_o     = tx_valid_q;
  assign bus.fifo_level_o   = level_q;
  assign bus.overflow_o     = overflow_q;
  assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_uart_word_bridge.sv
// Scoreboard bench for uart_word_bridge: two instances (4/4 bytes, depth 4,
// timeout 100; and 2/3 bytes, depth 8) driven by directed vectors.
module tb_uart_word_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_word_bridge_if #(.BYTES_IN(4), .BYTES_OUT(4), .FIFO_DEPTH(4)) a_if ();
  uart_word_bridge_if #(.BYTES_IN(2), .BYTES_OUT(3), .FIFO_DEPTH(8)) b_if ();

  uart_word_bridge #(.BYTES_IN(4), .BYTES_OUT(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  uart_word_bridge #(.BYTES_IN(2), .BYTES_OUT(3), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(0))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int n_checks = 0;
  int n_pass   = 0;
  int to_cnt_a = 0;
  logic hold_busy = 1'b0;

  logic [31:0] exp_sa[$];
  logic [15:0] exp_sb[$];
  logic [7:0]  exp_ta[$];
  logic [7:0]  exp_tb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_extra(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: unexpected output %0h, expected none", name, act);
  endtask

  // Scoreboard monitor: pops an expectation whenever a DUT output strobes.
  always @(negedge clk) begin
    if (a_if.sample_valid_o) begin
      if (exp_sa.size() == 0) fail_extra("sample_a", a_if.sample_o);
      else check("sample_a", a_if.sample_o, exp_sa.pop_front());
    end
    if (a_if.tx_valid_o) begin
      check("tx_a_busy_low", a_if.tx_busy_i, 0);
      if (exp_ta.size() == 0) fail_extra("tx_a", a_if.tx_data_o);
      else check("tx_a", a_if.tx_data_o, exp_ta.pop_front());
    end
    if (a_if.timeout_o) to_cnt_a++;
    if (b_if.sample_valid_o) begin
      if (exp_sb.size() == 0) fail_extra("sample_b", b_if.sample_o);
      else check("sample_b", b_if.sample_o, exp_sb.pop_front());
    end
    if (b_if.tx_valid_o) begin
      if (exp_tb.size() == 0) fail_extra("tx_b", b_if.tx_data_o);
      else check("tx_b", b_if.tx_data_o, exp_tb.pop_front());
    end
  end

  // Transmitter model for instance A: busy for 10 cycles after each send strobe.
  initial begin
    int  bcnt = 0;
    logic sv;
    a_if.tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      sv = a_if.tx_valid_o;
      @(posedge clk);
      #2;
      if (sv) bcnt = 10;
      else if (bcnt != 0) bcnt--;
      a_if.tx_busy_i = hold_busy || (bcnt != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic rx_a(input logic [7:0] b);
    a_if.rx_data_i = b; a_if.rx_valid_i = 1'b1;
    @(posedge clk); #1;
    a_if.rx_valid_i = 1'b0;
  endtask

  task automatic rx_b(input logic [7:0] b);
    b_if.rx_data_i = b; b_if.rx_valid_i = 1'b1;
    @(posedge clk); #1;
    b_if.rx_valid_i = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] w);
    a_if.result_i = w; a_if.result_valid_i = 1'b1;
    @(posedge clk); #1;
    a_if.result_valid_i = 1'b0;
  endtask

  task automatic push_b(input logic [23:0] w);
    b_if.result_i = w; b_if.result_valid_i = 1'b1;
    @(posedge clk); #1;
    b_if.result_valid_i = 1'b0;
  endtask

  task automatic exp_word_a(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_ta.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_ta.size() != 0 || exp_tb.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_ta.size() + exp_tb.size(), 0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_sample"},   a_if.sample_o, 0);
    check({tag, "_svalid"},   a_if.sample_valid_o, 0);
    check({tag, "_ready"},    a_if.result_ready_o, 1);
    check({tag, "_txdata"},   a_if.tx_data_o, 0);
    check({tag, "_txvalid"},  a_if.tx_valid_o, 0);
    check({tag, "_level"},    a_if.fifo_level_o, 0);
    check({tag, "_overflow"}, a_if.overflow_o, 0);
    check({tag, "_timeout"},  a_if.timeout_o, 0);
  endtask

  initial begin
    a_if.rx_data_i = '0; a_if.rx_valid_i = 1'b0;
    a_if.result_i = '0;  a_if.result_valid_i = 1'b0;
    b_if.rx_data_i = '0; b_if.rx_valid_i = 1'b0;
    b_if.result_i = '0;  b_if.result_valid_i = 1'b0;
    b_if.tx_busy_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("reset");
    rst = 1'b0;

    // Packing 4 bytes; sample strobes the cycle after the 4th byte.
    exp_sa.push_back(32'h12345678);
    rx_a(8'h12); rx_a(8'h34); rx_a(8'h56); rx_a(8'h78);
    check("sample_latency", a_if.sample_valid_o, 1);
    repeat (3) @(posedge clk);
    #1;

    // Partial frame discarded after 100 idle cycles.
    rx_a(8'h01); rx_a(8'h02);
    repeat (99) @(posedge clk);
    #1;
    check("timeout_not_early", a_if.timeout_o, 0);
    @(posedge clk); #1;
    check("timeout_at_100", a_if.timeout_o, 1);
    @(posedge clk); #1;
    check("timeout_one_pulse", a_if.timeout_o, 0);
    exp_sa.push_back(32'hAABBCCDD);
    rx_a(8'hAA); rx_a(8'hBB); rx_a(8'hCC); rx_a(8'hDD);
    repeat (3) @(posedge clk);
    #1;

    // A byte on the expiry cycle is accepted and suppresses the timeout.
    exp_sa.push_back(32'h11223344);
    rx_a(8'h11);
    repeat (99) @(posedge clk);
    #1;
    rx_a(8'h22); rx_a(8'h33); rx_a(8'h44);
    repeat (3) @(posedge clk);
    #1;
    check("timeout_count", to_cnt_a, 1);

    // Single word through the busy transmitter model.
    exp_word_a(32'hDEADBEEF);
    push_a(32'hDEADBEEF);
    check("level_after_push", a_if.fifo_level_o, 1);
    @(posedge clk); #1;
    check("first_tx_latency", a_if.tx_valid_o, 1);
    wait_drain("deadbeef_drain");
    repeat (20) @(posedge clk);
    #1;
    check("deadbeef_level", a_if.fifo_level_o, 0);

    // Overflow with the transmitter stalled.
    hold_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_a(32'h1); push_a(32'h2); push_a(32'h3);
    check("ready_after_3", a_if.result_ready_o, 1);
    push_a(32'h4);
    check("ready_after_4", a_if.result_ready_o, 0);
    check("level_full", a_if.fifo_level_o, 4);
    check("no_overflow_yet", a_if.overflow_o, 0);
    push_a(32'h5);
    check("level_after_drop", a_if.fifo_level_o, 4);
    check("overflow_set", a_if.overflow_o, 1);
    for (int w = 1; w <= 4; w++) exp_word_a(32'(w));
    hold_busy = 1'b0;
    wait_drain("overflow_drain");
    repeat (20) @(posedge clk);
    #1;
    check("overflow_sticky", a_if.overflow_o, 1);
    check("overflow_level", a_if.fifo_level_o, 0);

    // Reset during the 2nd byte of a word with 2 more words queued.
    hold_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_a(32'hAABBCCDD); push_a(32'h11223344); push_a(32'h55667788);
    exp_ta.push_back(8'hAA); exp_ta.push_back(8'hBB);
    hold_busy = 1'b0;
    wait_drain("pre_reset_drain");
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_a("midreset");
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("post_reset_level", a_if.fifo_level_o, 0);
    exp_word_a(32'h0BADF00D);
    push_a(32'h0BADF00D);
    wait_drain("post_reset_drain");

    // Instance B: 2-byte samples, 3-byte words.
    exp_sb.push_back(16'hABCD);
    rx_b(8'hAB); rx_b(8'hCD);
    check("sample_b_latency", b_if.sample_valid_o, 1);
    exp_tb.push_back(8'h12); exp_tb.push_back(8'h34); exp_tb.push_back(8'h56);
    push_b(24'h123456);
    wait_drain("b_drain");
    repeat (20) @(posedge clk);
    #1;
    check("b_level", b_if.fifo_level_o, 0);
    check("samples_a_consumed", exp_sa.size(), 0);
    check("samples_b_consumed", exp_sb.size(), 0);
    check("timeout_count_final", to_cnt_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_word_bridge.md
# uart_word_bridge

Parametrised byte/word bridge between the UART receiver/transmitter and the demodulator datapath. It packs received bytes MSB-first into samples of BYTES_IN bytes. It buffers result words of BYTES_OUT bytes in a word FIFO and serialises them to the UART transmitter under a busy handshake. It supersedes the fixed 4-byte merge/split pair by adding configurable widths, output buffering with backpressure, overflow reporting and partial-frame timeout resync.

## Interface
- BYTES_IN, 4: bytes per input sample (1..8).
- BYTES_OUT, 4: bytes per result word (1..8).
- FIFO_DEPTH, 8: result-word FIFO depth; power of two, ≥2.
- TIMEOUT_CYCLES, 1000000: idle cycles after which a partial input frame is discarded; 0 disables the timeout.
- clk  in  1  system clock (PLL logic clock); one clock domain only.
- rst  in  1  reset; synchronous, active-high.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i.
- sample_o  out  8*BYTES_IN  assembled sample; first received byte in the MSBs.
- sample_valid_o  out  1  one-cycle strobe qualifying sample_o.
- result_i  in  8*BYTES_OUT  result word from the datapath.
- result_valid_i  in  1  push strobe for result_i.
- result_ready_o  out  1  high when the FIFO is not full.
- tx_data_o  out  8  byte to transmitter.
- tx_valid_o  out  1  one-cycle send strobe.
- tx_busy_i  in  1  transmitter busy.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  number of stored words.
- overflow_o  out  1  sticky: a result word was dropped.
- timeout_o  out  1  one-cycle strobe: a partial frame was discarded.

## Operation
- Reset values: sample_o=0, sample_valid_o=0, result_ready_o=1, tx_data_o=0, tx_valid_o=0, fifo_level_o=0, overflow_o=0, timeout_o=0. The byte counter, FIFO pointers and TX FSM return to zero/IDLE. Reset mid-frame or mid-transmission discards everything; no further tx_valid_o is issued.
- Packing: on each rx_valid_i, the shift register shifts left by 8 and inserts rx_data_i. When the byte count reaches BYTES_IN, sample_o is loaded and sample_valid_o pulses; the count wraps to 0.
- Timeout: an idle counter is cleared on every rx_valid_i and runs only while the byte count ≠0. When it reaches TIMEOUT_CYCLES:
  - the byte count is cleared;
  - timeout_o pulses;
  - the counter stops.
  If rx_valid_i arrives in the same cycle as the expiry, the byte is accepted and the timeout does not fire.
- FIFO push: result_valid_i && result_ready_o writes result_i. result_valid_i while full drops the word and sets overflow_o, which clears only on rst. A push that arrives while full is dropped even if a pop happens in the same cycle. A push and a pop in the same non-full cycle leave fifo_level_o unchanged.
- TX FSM states: IDLE, SEND, GUARD, DRAIN.
  - IDLE -> SEND when the FIFO is not empty and tx_busy_i=0. The head word is popped into the output shift register and the byte index is set to 0.
  - SEND: tx_valid_o=1 and tx_data_o = current MSB byte. -> GUARD.
  - GUARD: one cycle, tx_busy_i is ignored. -> DRAIN.
  - DRAIN: wait for tx_busy_i=0, then:
    - more bytes remain: shift, -> SEND;
    - word done and FIFO not empty: pop, -> SEND;
    - otherwise -> IDLE.
- The RX and TX paths are independent; sample and result traffic may overlap in the same cycle.

## Timing
- sample_valid_o is registered: it rises one cycle after the rx_valid_i carrying the last byte.
- The first tx_valid_o occurs 2 cycles after the push cycle when the FIFO was empty and tx_busy_i=0 (push, IDLE->SEND, SEND).
- Minimum byte spacing is 3 cycles (SEND, GUARD, DRAIN), or longer while tx_busy_i is held.
- tx_data_o is stable from SEND until the next SEND.
- fifo_level_o and result_ready_o update one cycle after a push or pop.

## Test plan
- BYTES_IN=4: rx bytes 0x12,0x34,0x56,0x78 -> exactly one sample_valid_o, with sample_o=0x12345678, one cycle after the 4th strobe.
- TIMEOUT_CYCLES=100: bytes 0x01,0x02, then 100 idle cycles -> timeout_o pulses once, no sample. Then bytes 0xAA,0xBB,0xCC,0xDD -> sample_o=0xAABBCCDD.
- Push 0xDEADBEEF with a transmitter model that is busy for 10 cycles per byte -> tx bytes DE,AD,BE,EF in order. Check exactly 4 tx_valid_o pulses, each while tx_busy_i=0, and fifo_level_o back to 0.
- FIFO_DEPTH=4, tx_busy_i held at 1, push 5 words 0x1..0x5 -> result_ready_o falls after the 4th push, word 0x5 is dropped, overflow_o=1, fifo_level_o=4. After tx_busy_i is released -> 16 bytes for words 0x1..0x4 only; overflow_o stays 1.
- Reset asserted during the 2nd byte of a word, with 2 words queued -> all outputs at reset values next cycle, no further tx_valid_o. A push after reset is transmitted normally.
- BYTES_IN=2, BYTES_OUT=3: rx bytes 0xAB,0xCD -> sample_o=0xABCD. Push 0x123456 -> tx bytes 12,34,56.
